// File: rtl/reset_requester_pkg.sv
// Shared definitions for the soft-reset requester: FSM encoding, default key and
// status register layout. Used with or without RESET_REQUESTER_LINK_WATCHDOG_EN.
package reset_requester_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_HOLDOFF = 2'd1;
    localparam state_t ST_FIRE    = 2'd2;
    localparam state_t ST_LOCKOUT = 2'd3;

    localparam logic [31:0] DEFAULT_KEY     = 32'h5AFE_C0DE;
    localparam logic [15:0] DEFAULT_WB_ADDR = 16'h0040;

    localparam int STATUS_BUSY_BIT  = 31;
    localparam int STATUS_TRIP_BIT  = 30;
    localparam int STATUS_COUNT_MSB = 15;
    localparam int STATUS_COUNT_LSB = 0;

    function automatic logic [31:0] pack_status(input logic busy, input logic trip,
                                                input logic [15:0] count);
        logic [31:0] word;
        word = '0;
        word[STATUS_BUSY_BIT] = busy;
        word[STATUS_TRIP_BIT] = trip;
        word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
        return word;
    endfunction

endpackage

// File: rtl/reset_requester_link_watchdog.sv
// Counts consecutive link-bad cycles while the requester is idle and raises a trip
// once the limit is reached. Only instantiated with RESET_REQUESTER_LINK_WATCHDOG_EN.
module link_watchdog #(
    parameter int unsigned WATCHDOG_CYCLES = 2**20 - 1
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic idle_i,
    input  logic clear_i,
    input  logic gbt_rxready_i,
    input  logic gbt_rxvalid_i,
    output logic trip_o
);

    localparam int CNT_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WATCHDOG_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             link_good;

    assign link_good = gbt_rxready_i & gbt_rxvalid_i;
    assign trip_o    = idle_i && (cnt_q == LIMIT);

    // Any exit from IDLE (trip or accepted key) restarts the count from zero.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!idle_i || clear_i || trip_o || link_good) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_requester.sv
// Soft-reset requester: key write (or link-loss watchdog when
// RESET_REQUESTER_LINK_WATCHDOG_EN is defined) yields a one-cycle soft_reset_o strobe.
module reset_requester
    import reset_requester_pkg::*;
#(
    parameter logic [15:0] WB_ADDR         = DEFAULT_WB_ADDR,
    parameter logic [31:0] KEY             = DEFAULT_KEY,
    parameter int unsigned HOLDOFF_CYCLES  = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 1100,
    parameter int unsigned WATCHDOG_CYCLES = 2**20 - 1
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        wb_req_en_i,
    input  logic        wb_req_we_i,
    input  logic [15:0] wb_req_addr_i,
    input  logic [31:0] wb_req_data_i,
    output logic        wb_res_ack_o,
    output logic        wb_res_err_o,
    output logic [31:0] wb_res_data_o,
    input  logic        gbt_rxready_i,
    input  logic        gbt_rxvalid_i,
    output logic        soft_reset_o,
    output logic [15:0] reset_count_o,
    output logic        busy_o
);

    localparam logic [15:0] HOLDOFF_LIMIT = 16'(HOLDOFF_CYCLES);
    localparam logic [15:0] LOCKOUT_LIMIT = 16'(LOCKOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] count_q, count_d;
    logic        trip_flag_q, trip_flag_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        strobe_q, strobe_d;

    logic addr_hit;
    logic key_write;
    logic wd_trip;
    logic busy;

    assign busy      = (state_q != ST_IDLE);
    assign addr_hit  = wb_req_en_i && (wb_req_addr_i == WB_ADDR);
    assign key_write = addr_hit && wb_req_we_i && (wb_req_data_i == KEY) && (state_q == ST_IDLE);

`ifdef RESET_REQUESTER_LINK_WATCHDOG_EN
    link_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_link_watchdog (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .idle_i       (state_q == ST_IDLE),
        .clear_i      (key_write),
        .gbt_rxready_i(gbt_rxready_i),
        .gbt_rxvalid_i(gbt_rxvalid_i),
        .trip_o       (wd_trip)
    );
`else
    assign wd_trip = 1'b0;
    wire link_unused = &{1'b0, gbt_rxready_i, gbt_rxvalid_i, WATCHDOG_CYCLES[0]};
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        count_d     = count_q;
        trip_flag_d = trip_flag_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        strobe_d    = 1'b0;

        if (addr_hit) begin
            if (!wb_req_we_i) begin
                ack_d   = 1'b1;
                rdata_d = pack_status(busy, trip_flag_q, count_q);
            end else if (key_write) begin
                ack_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // Strobe and count are registered on entry to FIRE so both appear in the FIRE cycle.
        case (state_q)
            ST_IDLE: begin
                if (key_write) begin
                    state_d     = ST_HOLDOFF;
                    phase_d     = 16'd1;
                    trip_flag_d = 1'b0;
                end else if (wd_trip) begin
                    state_d     = ST_FIRE;
                    strobe_d    = 1'b1;
                    count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    trip_flag_d = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (phase_q == HOLDOFF_LIMIT) begin
                    state_d  = ST_FIRE;
                    strobe_d = 1'b1;
                    count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_FIRE: begin
                state_d = ST_LOCKOUT;
                phase_d = 16'd1;
            end
            default: begin
                if (phase_q == LOCKOUT_LIMIT) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            count_q     <= '0;
            trip_flag_q <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            trip_flag_q <= trip_flag_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            strobe_q    <= strobe_d;
        end
    end

    assign wb_res_ack_o  = ack_q;
    assign wb_res_err_o  = err_q;
    assign wb_res_data_o = rdata_q;
    assign soft_reset_o  = strobe_q;
    assign reset_count_o = count_q;
    assign busy_o        = busy;

endmodule

// File: doc/reset_requester.md
# reset_requester

Issues the soft-reset request that the startup/soft-reset generator consumes. A slow-control (wishbone) write carrying a key, or, optionally, a prolonged GBT link loss, produces a single-cycle `soft_reset_o` strobe. The requester acknowledges the wishbone transaction before firing, then locks out further requests until the downstream reset sequence has started. It sits between the wishbone slave splitter and the reset generator in the control block.

## Interface
- `WB_ADDR`, 16'h0040: base register address; the block owns `WB_ADDR` only.
- `KEY`, 32'h5AFE_C0DE: write data that triggers a reset.
- `HOLDOFF_CYCLES`, 16: cycles between `wb_res_ack_o` and `soft_reset_o`. Legal range is ≥1.
- `LOCKOUT_CYCLES`, 1100: cycles after the strobe during which requests are refused. This exceeds the downstream 1023-cycle delay plus margin.
- `WATCHDOG_CYCLES`, 2**20-1: consecutive link-bad cycles before an automatic request. Used only with the macro defined.
- `clock_i` in 1: 40 MHz fabric clock; only clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `wb_req_en_i` in 1: request strobe, one cycle per transaction.
- `wb_req_we_i` in 1: 1 = write.
- `wb_req_addr_i` in 16: register address.
- `wb_req_data_i` in 32: write data.
- `wb_res_ack_o` out 1: one-cycle acknowledge.
- `wb_res_err_o` out 1: one-cycle error; never asserted together with ack.
- `wb_res_data_o` out 32: read data, valid with ack.
- `gbt_rxready_i`, `gbt_rxvalid_i` in 1 each: link status inputs.
- `soft_reset_o` out 1: one-cycle reset request strobe.
- `reset_count_o` out 16: number of strobes issued, saturating.
- `busy_o` out 1: high when the FSM is not in IDLE.

## Operation
- Reset (`reset_n_i`=0 at an edge) forces the following on the next edge:
  - state IDLE;
  - all outputs 0, including `reset_count_o`;
  - all counters 0.
- Reset mid-sequence aborts the sequence with no strobe.
- States and transitions:
  - IDLE → HOLDOFF on a key write.
  - IDLE → FIRE on a watchdog trip.
  - HOLDOFF → FIRE when the holdoff counter reaches `HOLDOFF_CYCLES`.
  - FIRE → LOCKOUT after 1 cycle.
  - LOCKOUT → IDLE when the lockout counter reaches `LOCKOUT_CYCLES`.
- Key write: `wb_req_en_i`=1, `we`=1, `addr`=`WB_ADDR`, `data`=`KEY`, while in IDLE. The block responds with ack.
- Write to `WB_ADDR` with data ≠ `KEY`, or any key write outside IDLE: the block responds with err. No state change.
- Read of `WB_ADDR` in any state: the block responds with ack. Data layout:
  - bit 31 = `busy_o`;
  - bit 30 = watchdog-trip sticky flag;
  - bits 29:16 = 0;
  - bits 15:0 = `reset_count_o`.
- Other addresses: no response; the address belongs to another slave.
- `wb_res_data_o` is 0 except on read acks.
- In FIRE, `soft_reset_o`=1 and `reset_count_o` increments. The count saturates at 16'hFFFF.
- The watchdog-trip sticky flag clears on reset or on any key-triggered request.

## Timing
- Every response is registered, 1 cycle after `wb_req_en_i`.
- Key write at edge N:
  - `wb_res_ack_o`=1 at N+1.
  - HOLDOFF spans N+1..N+`HOLDOFF_CYCLES`.
  - `soft_reset_o`=1 exactly at cycle N+`HOLDOFF_CYCLES`+1.
  - `reset_count_o` updates the same cycle.
- LOCKOUT is `LOCKOUT_CYCLES` cycles. `busy_o` falls in the cycle after the last lockout cycle.
- Back-to-back wishbone requests on consecutive cycles each receive a response on the following cycle.
- A key write and a watchdog trip in the same IDLE cycle: the wishbone request wins (ack and HOLDOFF path), and the watchdog counter clears.

## Configuration
- With `RESET_REQUESTER_LINK_WATCHDOG_EN` defined:
  - A counter increments each cycle while `~(gbt_rxready_i & gbt_rxvalid_i)`.
  - It clears when the link is good.
  - On reaching `WATCHDOG_CYCLES` in IDLE, it trips: FIRE next cycle, no wishbone response, sticky flag set, counter cleared.
  - The counter holds at 0 outside IDLE.
- Without the macro: no watchdog logic, bit 30 reads 0, and the GBT inputs are unused.

## Structure
- Shared package `reset_requester_pkg` holds:
  - the state enum (IDLE, HOLDOFF, FIRE, LOCKOUT);
  - default `KEY`;
  - register bit positions (busy 31, trip 30, count 15:0).
- One natural sub-module, `link_watchdog`: the counter and trip logic. It is instantiated only under the macro.

## Test plan
- Reset, then write `KEY` to 0x0040 at cycle 10 → ack at 11, `soft_reset_o` pulse at 27, `reset_count_o`=1, `busy_o` low at 1128.
- Write 32'h0 to 0x0040 → err at the next cycle, no strobe, count unchanged. Read 0x0040 → ack with data 32'h0000_0000.
- Key write during LOCKOUT → err, no second strobe. Read during HOLDOFF → ack with bit 31=1.
- Macro on, `WATCHDOG_CYCLES`=100, drop `gbt_rxready_i` for 100 cycles → strobe with no ack, then read shows bit 30=1. A 99-cycle drop → no strobe.
- Key write and watchdog trip in the same cycle → ack, strobe at N+17, single count increment.
- Drive `reset_n_i` low during HOLDOFF → no strobe; outputs 0 on the next edge; count 0.
